// File: rtl/contact_scheduler.sv
`timescale 1ns/1ps
// Contact scheduler: queues contacts, fetches both bodies, waits for the resolver, writes impulses back.
// Optional build flag CONTACT_SCHED_SELF_FILTER_EN drops self-contacts (idx_a == idx_b) at the input.
module contact_scheduler #(
    parameter int FIFO_DEPTH  = 8,
    parameter int IDX_W       = 4,
    parameter int CONTACT_W   = 96,
    parameter int BODY_W      = 160,
    parameter int IMP_W       = 96,
    parameter int RESOLVE_LAT = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 c_valid,
    output logic                 c_ready,
    input  logic [IDX_W-1:0]     c_idx_a,
    input  logic [IDX_W-1:0]     c_idx_b,
    input  logic [CONTACT_W-1:0] c_data,
    input  logic                 flush,
    output logic                 busy,
    output logic                 done,
    output logic                 body_rd_en,
    output logic [IDX_W-1:0]     body_rd_idx,
    input  logic [BODY_W-1:0]    body_rd_data,
    output logic [CONTACT_W-1:0] res_contact,
    output logic [BODY_W-1:0]    res_obb1,
    output logic [BODY_W-1:0]    res_obb2,
    input  logic [IMP_W-1:0]     res_imp1,
    input  logic [IMP_W-1:0]     res_imp2,
    input  logic                 res_ignore,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [IDX_W-1:0]     wb_idx,
    output logic [IMP_W-1:0]     wb_impulse,
    output logic [15:0]          resolved_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE, ST_RD_A, ST_RD_B, ST_CAP_B, ST_SETTLE, ST_CAPTURE, ST_WB_A, ST_WB_B
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_fifo_a    [FIFO_DEPTH];
    logic [IDX_W-1:0]       r_fifo_b    [FIFO_DEPTH];
    logic [CONTACT_W-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W:0]         r_count;
    logic                   r_flush_pend;
    logic [IDX_W-1:0]       r_idx_a;
    logic [IDX_W-1:0]       r_idx_b;
    logic [CONTACT_W-1:0]   r_contact;
    logic [BODY_W-1:0]      r_obb1;
    logic [BODY_W-1:0]      r_obb2;
    logic [IMP_W-1:0]       r_imp2;
    logic [3:0]             r_settle_cnt;
    logic                   r_body_rd_en;
    logic [IDX_W-1:0]       r_body_rd_idx;
    logic                   r_wb_valid;
    logic [IDX_W-1:0]       r_wb_idx;
    logic [IMP_W-1:0]       r_wb_impulse;
    logic [15:0]            r_resolved_cnt;

    logic w_full, w_empty, w_keep, w_push, w_pop, w_done;

`ifdef CONTACT_SCHED_SELF_FILTER_EN
    assign w_keep = (c_idx_a != c_idx_b);
`else
    assign w_keep = 1'b1;
`endif

    // A full queue refuses input even when the head is leaving this cycle.
    assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = c_valid && !w_full && w_keep;
    assign w_pop   = (r_state == ST_IDLE) && !w_empty;
    assign w_done  = r_flush_pend && (r_state == ST_IDLE) && w_empty;

    assign c_ready      = !w_full;
    assign busy         = (r_state != ST_IDLE) || !w_empty;
    assign done         = w_done;
    assign body_rd_en   = r_body_rd_en;
    assign body_rd_idx  = r_body_rd_idx;
    assign res_contact  = r_contact;
    assign res_obb1     = r_obb1;
    assign res_obb2     = r_obb2;
    assign wb_valid     = r_wb_valid;
    assign wb_idx       = r_wb_idx;
    assign wb_impulse   = r_wb_impulse;
    assign resolved_cnt = r_resolved_cnt;

    // NOTE: queue storage has no reset; occupancy is tracked by the reset pointers, so stale entries are never read.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_fifo_a[r_wr_ptr]    <= c_idx_a;
            r_fifo_b[r_wr_ptr]    <= c_idx_b;
            r_fifo_data[r_wr_ptr] <= c_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset)       r_flush_pend <= 1'b0;
        else if (flush)  r_flush_pend <= 1'b1;
        else if (w_done) r_flush_pend <= 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state        <= ST_IDLE;
            r_idx_a        <= '0;
            r_idx_b        <= '0;
            r_contact      <= '0;
            r_obb1         <= '0;
            r_obb2         <= '0;
            r_imp2         <= '0;
            r_settle_cnt   <= '0;
            r_body_rd_en   <= 1'b0;
            r_body_rd_idx  <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_idx       <= '0;
            r_wb_impulse   <= '0;
            r_resolved_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_done) r_resolved_cnt <= '0;
                    if (!w_empty) begin
                        r_contact     <= r_fifo_data[r_rd_ptr];
                        r_idx_a       <= r_fifo_a[r_rd_ptr];
                        r_idx_b       <= r_fifo_b[r_rd_ptr];
                        r_body_rd_en  <= 1'b1;
                        r_body_rd_idx <= r_fifo_a[r_rd_ptr];
                        r_state       <= ST_RD_A;
                    end
                end
                ST_RD_A: begin
                    r_body_rd_idx <= r_idx_b;
                    r_state       <= ST_RD_B;
                end
                ST_RD_B: begin
                    r_obb1       <= body_rd_data;
                    r_body_rd_en <= 1'b0;
                    r_state      <= ST_CAP_B;
                end
                ST_CAP_B: begin
                    r_obb2       <= body_rd_data;
                    r_settle_cnt <= 4'(RESOLVE_LAT - 1);
                    r_state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == '0) r_state <= ST_CAPTURE;
                    else                    r_settle_cnt <= r_settle_cnt - 4'd1;
                end
                ST_CAPTURE: begin
                    r_imp2 <= res_imp2;
                    if (r_resolved_cnt != 16'hFFFF) r_resolved_cnt <= r_resolved_cnt + 16'd1;
                    if (res_ignore) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wb_valid   <= 1'b1;
                        r_wb_idx     <= r_idx_a;
                        r_wb_impulse <= res_imp1;
                        r_state      <= ST_WB_A;
                    end
                end
                ST_WB_A: begin
                    if (wb_ready) begin
                        r_wb_idx     <= r_idx_b;
                        r_wb_impulse <= r_imp2;
                        r_state      <= ST_WB_B;
                    end
                end
                ST_WB_B: begin
                    if (wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_contact_scheduler.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for contact_scheduler with behavioural body RAM and resolver models.
module tb_contact_scheduler;

    localparam int FIFO_DEPTH  = 8;
    localparam int IDX_W       = 4;
    localparam int CONTACT_W   = 96;
    localparam int BODY_W      = 160;
    localparam int IMP_W       = 96;
    localparam int RESOLVE_LAT = 2;

    logic                 Clk = 1'b0;
    logic                 Reset = 1'b1;
    logic                 c_valid = 1'b0;
    logic                 c_ready;
    logic [IDX_W-1:0]     c_idx_a = '0;
    logic [IDX_W-1:0]     c_idx_b = '0;
    logic [CONTACT_W-1:0] c_data = '0;
    logic                 flush = 1'b0;
    logic                 busy, done;
    logic                 body_rd_en;
    logic [IDX_W-1:0]     body_rd_idx;
    logic [BODY_W-1:0]    body_rd_data = '0;
    logic [CONTACT_W-1:0] res_contact;
    logic [BODY_W-1:0]    res_obb1, res_obb2;
    logic [IMP_W-1:0]     res_imp1 = '0;
    logic [IMP_W-1:0]     res_imp2 = '0;
    logic                 res_ignore = 1'b0;
    logic                 wb_valid;
    logic                 wb_ready = 1'b1;
    logic [IDX_W-1:0]     wb_idx;
    logic [IMP_W-1:0]     wb_impulse;
    logic [15:0]          resolved_cnt;

    contact_scheduler #(
        .FIFO_DEPTH(FIFO_DEPTH), .IDX_W(IDX_W), .CONTACT_W(CONTACT_W),
        .BODY_W(BODY_W), .IMP_W(IMP_W), .RESOLVE_LAT(RESOLVE_LAT)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .c_valid(c_valid), .c_ready(c_ready), .c_idx_a(c_idx_a), .c_idx_b(c_idx_b), .c_data(c_data),
        .flush(flush), .busy(busy), .done(done),
        .body_rd_en(body_rd_en), .body_rd_idx(body_rd_idx), .body_rd_data(body_rd_data),
        .res_contact(res_contact), .res_obb1(res_obb1), .res_obb2(res_obb2),
        .res_imp1(res_imp1), .res_imp2(res_imp2), .res_ignore(res_ignore),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_idx(wb_idx), .wb_impulse(wb_impulse),
        .resolved_cnt(resolved_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [IMP_W-1:0] imp;
    } wb_t;

    wb_t              exp_wb[$];
    logic [IDX_W-1:0] exp_rd[$];
    int  n_checks = 0;
    int  n_pass = 0;
    int  cyc = 0;
    int  last_wb_cyc = 0;
    int  n_reads = 0;
    int  n_done = 0;
    int  m_resolved = 0;
    bit  m_flush_pend = 0;
    bit  prev_stall = 0;
    logic [IDX_W-1:0] prev_idx;
    logic [IMP_W-1:0] prev_imp;

    function automatic logic [BODY_W-1:0] body_fn(input logic [IDX_W-1:0] idx);
        logic [31:0] h;
        h = ({28'd0, idx} + 32'd1) * 32'h9E3779B1;
        return {h, ~h, h ^ 32'h00FF_FF00, h + 32'd12345, {idx, 28'h0BCDEF1}};
    endfunction

    function automatic logic [IMP_W-1:0] imp_fn(input logic [CONTACT_W-1:0] c, input logic [BODY_W-1:0] obb,
                                                input bit second);
        logic [IMP_W-1:0] r;
        r = c ^ obb[95:0] ^ {obb[159:128], obb[127:96], obb[159:128]};
        if (second) r = {r[47:0], r[95:48]};
        return r;
    endfunction

    function automatic logic ignore_fn(input logic [CONTACT_W-1:0] c);
        return c[0] & c[1];
    endfunction

    task automatic check(input string name, input logic [415:0] act, input logic [415:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    // Body RAM: one-cycle read latency.
    always @(posedge Clk) if (body_rd_en) body_rd_data <= body_fn(body_rd_idx);

    // Resolver: answers are only correct once its inputs have been stable for RESOLVE_LAT cycles.
    logic [CONTACT_W+2*BODY_W-1:0] res_prev = '0;
    int res_stable = 0;
    always @(negedge Clk) begin
        if ({res_contact, res_obb1, res_obb2} != res_prev) res_stable = 0;
        else if (res_stable < 15) res_stable++;
        res_prev = {res_contact, res_obb1, res_obb2};
        if (res_stable >= RESOLVE_LAT) begin
            res_imp1   = imp_fn(res_contact, res_obb1, 1'b0);
            res_imp2   = imp_fn(res_contact, res_obb2, 1'b1);
            res_ignore = ignore_fn(res_contact);
        end else begin
            res_imp1   = ~imp_fn(res_contact, res_obb1, 1'b0);
            res_imp2   = ~imp_fn(res_contact, res_obb2, 1'b1);
            res_ignore = ~ignore_fn(res_contact);
        end
    end

    // Scoreboard and monitor: acceptance pushes expectations, DUT activity pops and compares.
    always @(negedge Clk) begin
        if (Reset) begin
            prev_stall = 0;
        end else begin
            if (done) begin
                check("done_requested", m_flush_pend, 1);
                check("resolved_at_done", resolved_cnt, m_resolved);
                check("wb_drained_at_done", exp_wb.size(), 0);
                m_flush_pend = 0;
                m_resolved = 0;
                n_done++;
            end
            if (flush) m_flush_pend = 1;
            if (prev_stall)
                check("wb_stable", {wb_valid, wb_idx, wb_impulse}, {1'b1, prev_idx, prev_imp});
            prev_stall = wb_valid && !wb_ready;
            prev_idx = wb_idx;
            prev_imp = wb_impulse;
            if (wb_valid && wb_ready) begin
                check("wb_expected", exp_wb.size() != 0, 1);
                if (exp_wb.size() != 0) begin
                    wb_t e;
                    e = exp_wb.pop_front();
                    check("wb_idx_imp", {wb_idx, wb_impulse}, {e.idx, e.imp});
                end
                last_wb_cyc = cyc;
            end
            if (body_rd_en) begin
                n_reads++;
                check("rd_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) check("rd_idx", body_rd_idx, exp_rd.pop_front());
            end
            if (c_valid && c_ready) begin
                bit keep;
                keep = 1;
`ifdef CONTACT_SCHED_SELF_FILTER_EN
                keep = (c_idx_a != c_idx_b);
`endif
                if (keep) begin
                    m_resolved++;
                    exp_rd.push_back(c_idx_a);
                    exp_rd.push_back(c_idx_b);
                    if (!ignore_fn(c_data)) begin
                        exp_wb.push_back('{c_idx_a, imp_fn(c_data, body_fn(c_idx_a), 1'b0)});
                        exp_wb.push_back('{c_idx_b, imp_fn(c_data, body_fn(c_idx_b), 1'b1)});
                    end
                end
            end
        end
    end

    task automatic do_reset();
        Reset = 1'b1;
        exp_wb.delete();
        exp_rd.delete();
        m_flush_pend = 0;
        m_resolved = 0;
        @(posedge Clk); #1;
        Reset = 1'b0;
    endtask

    task automatic push_one(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b, input logic [CONTACT_W-1:0] d);
        bit acc;
        acc = 0;
        c_idx_a = a;
        c_idx_b = b;
        c_data  = d;
        c_valid = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge Clk);
            acc = c_ready;
            @(posedge Clk); #1;
            if (acc) break;
        end
        c_valid = 1'b0;
        check("push_accepted", acc, 1);
    endtask

    task automatic push_rand(input bit no_ignore, input bit distinct);
        logic [IDX_W-1:0] a, b;
        logic [CONTACT_W-1:0] d;
        a = IDX_W'($urandom_range(0, 15));
        b = distinct ? IDX_W'(a + IDX_W'($urandom_range(1, 15))) : IDX_W'($urandom_range(0, 15));
        d = {$urandom, $urandom, $urandom};
        if (no_ignore) d[1:0] = 2'b01;
        push_one(a, b, d);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 3000; k++) begin
            @(negedge Clk);
            if (!busy) break;
        end
        check("idle_reached", busy, 0);
        @(posedge Clk); #1;
    endtask

    task automatic wait_done(output int dc);
        bit seen;
        seen = 0;
        dc = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge Clk);
            if (done) begin
                seen = 1;
                dc = cyc;
                break;
            end
        end
        check("done_seen", seen, 1);
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(posedge Clk); #1;
        flush = 1'b0;
    endtask

    initial begin
        int bc, dc, pulses, rd0, wbv;
        bit stop;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("reset_outputs", {c_ready, busy, done, body_rd_en, wb_valid, wb_idx, wb_impulse},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 96'd0});
        check("reset_resolved", resolved_cnt, 0);
        @(posedge Clk); #1;

        // Single contact a=2, b=5: occupancy and count
        push_one(4'd2, 4'd5, 96'h1234_5678_9ABC_DEF0_0F1E_2D3D);
        bc = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge Clk);
            if (busy) bc++;
            else break;
        end
        check("single_busy_cycles", bc, 7 + RESOLVE_LAT);
        check("single_resolved", resolved_cnt, 1);
        @(posedge Clk); #1;

        // Flush while idle and empty
        flush_pulse();
        @(negedge Clk);
        check("idle_flush_done", {done, resolved_cnt}, {1'b1, 16'd1});
        @(negedge Clk);
        check("idle_flush_after", {done, resolved_cnt}, {1'b0, 16'd0});
        @(posedge Clk); #1;

        // Ignored contact
        push_one(4'd3, 4'd7, 96'hAAAA_5555_0000_FFFF_1357_9BDF);
        wait_idle();
        check("ignore_resolved", resolved_cnt, 1);

        // Fill the queue with writeback stalled
        wb_ready = 1'b0;
        for (int i = 0; i < 9; i++) push_rand(1, 1);
        @(negedge Clk);
        check("full_ready_low", {c_ready, busy}, {1'b0, 1'b1});
        @(posedge Clk); #1;
        wb_ready = 1'b1;
        wait_idle();
        check("fill_drained", exp_wb.size(), 0);

        // Toggling writeback ready
        fork
            begin
                repeat (150) begin
                    @(posedge Clk); #1;
                    wb_ready = ~wb_ready;
                end
            end
            begin
                for (int i = 0; i < 6; i++) push_rand(1, 0);
            end
        join
        wb_ready = 1'b1;
        wait_idle();

        // Flush with three queued
        flush_pulse();
        @(negedge Clk);
        @(posedge Clk); #1;
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_rand(1, 1);
        flush_pulse();
        wb_ready = 1'b1;
        wait_done(dc);
        check("done_after_last_wb", dc, last_wb_cyc + 1);
        check("flush3_resolved", resolved_cnt, 3);
        @(negedge Clk);
        check("flush3_cleared", resolved_cnt, 0);
        pulses = 0;
        repeat (10) begin
            @(negedge Clk);
            if (done) pulses++;
        end
        check("flush3_single_pulse", pulses, 0);
        @(posedge Clk); #1;

        // Contacts arriving after flush are finished before done
        for (int i = 0; i < 2; i++) push_rand(1, 1);
        flush_pulse();
        for (int i = 0; i < 2; i++) push_rand(1, 1);
        wait_done(dc);
        check("late_resolved", resolved_cnt, 4);
        @(posedge Clk); #1;

        // Random traffic
        stop = 0;
        fork
            begin
                while (!stop) begin
                    @(posedge Clk); #1;
                    wb_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge Clk); #1;
                    end
                    push_rand(0, 0);
                end
                stop = 1;
            end
        join
        wb_ready = 1'b1;
        wait_idle();
        check("random_drained", {exp_wb.size(), exp_rd.size()}, 64'd0);

        // Reset during SETTLE abandons the contact
        push_one(4'd6, 4'd9, 96'h0F0F_0F0F_1111_2222_3333_4445);
        for (int k = 0; k < 50; k++) begin
            @(negedge Clk);
            if (body_rd_en) break;
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge Clk);
            if (!body_rd_en) break;
        end
        @(posedge Clk); #1;
        do_reset();
        @(negedge Clk);
        check("settle_reset_outputs", {c_ready, busy, wb_valid, body_rd_en, done, resolved_cnt},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
        wbv = 0;
        repeat (20) begin
            @(negedge Clk);
            if (wb_valid) wbv++;
        end
        check("settle_reset_no_wb", wbv, 0);
        @(posedge Clk); #1;

        // Reset between the two writebacks of a pair
        wb_ready = 1'b0;
        push_one(4'd1, 4'd8, 96'h9999_8888_7777_6666_5555_4441);
        for (int k = 0; k < 50; k++) begin
            @(negedge Clk);
            if (wb_valid) break;
        end
        @(posedge Clk); #1;
        wb_ready = 1'b1;
        @(posedge Clk); #1;
        wb_ready = 1'b0;
        @(negedge Clk);
        check("half_pair_wb_b", {wb_valid, wb_idx}, {1'b1, 4'd8});
        @(posedge Clk); #1;
        do_reset();
        wb_ready = 1'b1;
        wbv = 0;
        repeat (20) begin
            @(negedge Clk);
            if (wb_valid) wbv++;
        end
        check("half_pair_no_wb", wbv, 0);
        @(posedge Clk); #1;

        // Self-contact a=b=4
        rd0 = n_reads;
        push_one(4'd4, 4'd4, 96'h0102_0304_0506_0708_090A_0B0D);
        repeat (15) @(negedge Clk);
`ifdef CONTACT_SCHED_SELF_FILTER_EN
        check("self_contact_reads", n_reads - rd0, 0);
`else
        check("self_contact_reads", n_reads - rd0, 2);
`endif
        @(posedge Clk); #1;
        wait_idle();
        check("final_queues_empty", {exp_wb.size(), exp_rd.size()}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
